// File: rtl/jt49_period_meas.sv
// jt49_period_meas: measures the interval between toggles of a square wave,
// in cen ticks. It is the inverse of the jt49 tone/noise/envelope divider:
// a divider programmed with period P toggles every P ticks, so this block
// reports P. Both edges of sq count as toggles.
//
// Optional feature (macro JT49_PMEAS_DUTY_EN): adds high_time/low_time,
// which report the interval that ended on a falling or rising edge.
module jt49_period_meas #(
  parameter int W     = 12,
  parameter int LOCKN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         clr,
  input  logic         sq,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         locked,
  output logic         timeout
`ifdef JT49_PMEAS_DUTY_EN
  ,
  output logic [W-1:0] high_time,
  output logic [W-1:0] low_time
`endif
);

  typedef enum logic [1:0] {
    ST_PRIME,
    ST_WAIT,
    ST_RUN
  } state_t;

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]   LOCK_TGT = 4'(LOCKN);

  state_t       state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic         sq_prev, sq_prev_nx;
  logic [3:0]   match, match_nx, match_new;
  logic [W-1:0] period_nx;
  logic         valid_nx, locked_nx, timeout_nx;
  logic         edge_det;
`ifdef JT49_PMEAS_DUTY_EN
  logic [W-1:0] high_time_nx, low_time_nx;
`endif

  assign edge_det = sq ^ sq_prev;

  // Next-state and next-output logic; clr overrides every cen-tick event.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sq_prev_nx   = sq_prev;
    match_nx     = match;
    match_new    = match;
    period_nx    = period;
    valid_nx     = 1'b0;
    locked_nx    = locked;
    timeout_nx   = timeout;
`ifdef JT49_PMEAS_DUTY_EN
    high_time_nx = high_time;
    low_time_nx  = low_time;
`endif
    if (clr) begin
      state_nx     = ST_PRIME;
      cnt_nx       = '0;
      sq_prev_nx   = 1'b0;
      match_nx     = '0;
      period_nx    = '0;
      locked_nx    = 1'b0;
      timeout_nx   = 1'b0;
`ifdef JT49_PMEAS_DUTY_EN
      high_time_nx = '0;
      low_time_nx  = '0;
`endif
    end else if (cen) begin
      sq_prev_nx = sq;
      case (state)
        ST_PRIME: begin
          // Only captures the reference level; no edge can be seen yet.
          state_nx = ST_WAIT;
          cnt_nx   = W'(1);
        end
        ST_WAIT, ST_RUN: begin
          if (edge_det) begin
            state_nx   = ST_RUN;
            cnt_nx     = W'(1);
            timeout_nx = 1'b0;
            if (state == ST_RUN) begin
              // A full interval between two edges has been measured.
              if (cnt == period) begin
                if (match < LOCK_TGT) match_new = match + 4'd1;
              end else begin
                match_new = 4'd1;
              end
              match_nx  = match_new;
              locked_nx = (match_new >= LOCK_TGT);
              period_nx = cnt;
              valid_nx  = 1'b1;
`ifdef JT49_PMEAS_DUTY_EN
              if (!sq) high_time_nx = cnt;
              else     low_time_nx  = cnt;
`endif
            end
          end else if (cnt == CNT_MAX) begin
            // Saturated without an edge: report once, then hold silent.
            if (!timeout) begin
              state_nx     = ST_WAIT;
              period_nx    = '0;
              timeout_nx   = 1'b1;
              valid_nx     = 1'b1;
              locked_nx    = 1'b0;
              match_nx     = '0;
`ifdef JT49_PMEAS_DUTY_EN
              high_time_nx = '0;
              low_time_nx  = '0;
`endif
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = ST_PRIME;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRIME;
      cnt       <= '0;
      sq_prev   <= 1'b0;
      match     <= '0;
      period    <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
`ifdef JT49_PMEAS_DUTY_EN
      high_time <= '0;
      low_time  <= '0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sq_prev   <= sq_prev_nx;
      match     <= match_nx;
      period    <= period_nx;
      valid     <= valid_nx;
      locked    <= locked_nx;
      timeout   <= timeout_nx;
`ifdef JT49_PMEAS_DUTY_EN
      high_time <= high_time_nx;
      low_time  <= low_time_nx;
`endif
    end
  end

endmodule

// File: tb/tb_jt49_period_meas.sv
// Testbench for jt49_period_meas: three instances (W=4/LOCKN=2,
// W=4/LOCKN=1, W=12/LOCKN=2) share one stimulus stream and are compared
// every clock against a reference model based on edge timestamps.
module tb_jt49_period_meas;

  logic clk = 1'b0;
  logic rst_n, cen, clr, sq;

  logic [3:0]  per_a, per_b;
  logic [11:0] per_c;
  logic        val_a, val_b, val_c;
  logic        lck_a, lck_b, lck_c;
  logic        tmo_a, tmo_b, tmo_c;
`ifdef JT49_PMEAS_DUTY_EN
  logic [3:0]  hi_a, hi_b, lo_a, lo_b;
  logic [11:0] hi_c, lo_c;
`endif

  always #5 clk = ~clk;

  jt49_period_meas #(.W(4), .LOCKN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr), .sq(sq),
    .period(per_a), .valid(val_a), .locked(lck_a), .timeout(tmo_a)
`ifdef JT49_PMEAS_DUTY_EN
    , .high_time(hi_a), .low_time(lo_a)
`endif
  );

  jt49_period_meas #(.W(4), .LOCKN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr), .sq(sq),
    .period(per_b), .valid(val_b), .locked(lck_b), .timeout(tmo_b)
`ifdef JT49_PMEAS_DUTY_EN
    , .high_time(hi_b), .low_time(lo_b)
`endif
  );

  jt49_period_meas #(.W(12), .LOCKN(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr), .sq(sq),
    .period(per_c), .valid(val_c), .locked(lck_c), .timeout(tmo_c)
`ifdef JT49_PMEAS_DUTY_EN
    , .high_time(hi_c), .low_time(lo_c)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remembers the cen-tick index of the last reference
  // point (prime tick or last edge); an interval is the tick difference.
  int lk[3] = '{2, 1, 2};
  int mx[3] = '{15, 15, 4095};
  int tick;
  bit primed[3], meas[3], m_tmo[3], sqp[3], m_val[3], m_lock[3];
  int refc[3], m_per[3], m_match[3], m_hi[3], m_lo[3];

  function automatic void mdl_reset(input int i);
    primed[i] = 0; meas[i] = 0; m_tmo[i] = 0; sqp[i] = 0;
    m_val[i] = 0; m_lock[i] = 0; refc[i] = 0; m_per[i] = 0;
    m_match[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
  endfunction

  task automatic model_step();
    int d;
    if (!rst_n) begin
      tick = 0;
      for (int i = 0; i < 3; i++) mdl_reset(i);
      return;
    end
    if (cen && !clr) tick++;
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0;
      if (clr) begin
        mdl_reset(i);
      end else if (cen) begin
        d = tick - refc[i];
        if (!primed[i]) begin
          primed[i] = 1;
          refc[i] = tick;
        end else if (sq != sqp[i]) begin
          if (meas[i]) begin
            if (d == m_per[i]) begin
              if (m_match[i] < lk[i]) m_match[i]++;
            end else begin
              m_match[i] = 1;
            end
            m_lock[i] = (m_match[i] >= lk[i]);
            m_per[i] = d;
            m_val[i] = 1;
            if (sq == 1'b0) m_hi[i] = d;
            else            m_lo[i] = d;
          end
          meas[i] = 1;
          m_tmo[i] = 0;
          refc[i] = tick;
        end else if (d == mx[i] && !m_tmo[i]) begin
          m_per[i] = 0; m_tmo[i] = 1; m_val[i] = 1; m_lock[i] = 0;
          m_match[i] = 0; meas[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
        end
        sqp[i] = sq;
      end
    end
  endtask

  task automatic check_all();
    chk("a", {val_a, tmo_a, lck_a, per_a}, {m_val[0], m_tmo[0], m_lock[0], 4'(m_per[0])});
    chk("b", {val_b, tmo_b, lck_b, per_b}, {m_val[1], m_tmo[1], m_lock[1], 4'(m_per[1])});
    chk("c", {val_c, tmo_c, lck_c, per_c}, {m_val[2], m_tmo[2], m_lock[2], 12'(m_per[2])});
`ifdef JT49_PMEAS_DUTY_EN
    chk("a_duty", {hi_a, lo_a}, {4'(m_hi[0]), 4'(m_lo[0])});
    chk("b_duty", {hi_b, lo_b}, {4'(m_hi[1]), 4'(m_lo[1])});
    chk("c_duty", {hi_c, lo_c}, {12'(m_hi[2]), 12'(m_lo[2])});
`endif
  endtask

  task automatic do_clk(input logic c, input logic cl, input logic s);
    cen = c; clr = cl; sq = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  logic sq_v = 1'b0;
  int   ph = 0;

  // Divider-like source: sq toggles every p cen ticks, cen every ce clocks.
  task automatic run_div(input int p, input int n, input int ce);
    int k = 0;
    int t = 0;
    logic c;
    while (t < n) begin
      c = ((k % ce) == 0);
      k++;
      if (c) begin
        t++;
        ph++;
        if (ph >= p) begin
          sq_v = ~sq_v;
          ph = 0;
        end
      end
      do_clk(c, 1'b0, sq_v);
    end
  endtask

  task automatic run_duty(input int hi, input int lo, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      sq_v = 1'b1;
      for (int t = 0; t < hi; t++) do_clk(1'b1, 1'b0, sq_v);
      sq_v = 1'b0;
      for (int t = 0; t < lo; t++) do_clk(1'b1, 1'b0, sq_v);
    end
  endtask

  int nval;

  initial begin
    rst_n = 1'b0; cen = 1'b0; clr = 1'b0; sq = 1'b0;
    model_step();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", {val_a, tmo_a, lck_a, per_a}, 7'd0);
    chk("rst_c", {val_c, tmo_c, lck_c, per_c}, 15'd0);
    rst_n = 1'b1;

    // Steady P=5, cen every clock.
    run_div(5, 40, 1);
    chk("p5_period", per_a, 4'd5);
    chk("p5_locked", {lck_a, tmo_a}, 2'b10);
    chk("p5_period_w12", per_c, 12'd5);

    // P=1 with sparse cen; valid must be one clock wide.
    nval = 0;
    for (int j = 0; j < 30; j++) begin
      do_clk((j % 3) == 0, 1'b0, ((j % 3) == 0) ? (sq_v = ~sq_v) : sq_v);
      if (val_a) nval++;
    end
    chk("p1_period", per_a, 4'd1);
    chk("p1_valid_count", nval, 10);

    // Switch 5 -> 9 mid-run.
    run_div(5, 20, 1);
    run_div(9, 60, 1);
    chk("p9_period", per_a, 4'd9);
    chk("p9_locked", lck_a, 1'b1);

    // Boundary: edge on the tick the counter saturates.
    run_div(15, 60, 1);
    chk("p15_period", per_a, 4'd15);
    chk("p15_no_timeout", tmo_a, 1'b0);

    // Lock at 5, then stop toggling until timeout; resume at P=3.
    ph = 0;
    run_div(5, 30, 1);
    for (int t = 0; t < 25; t++) do_clk(1'b1, 1'b0, sq_v);
    chk("tmo_flags", {tmo_a, lck_a, per_a}, {1'b1, 1'b0, 4'd0});
    chk("tmo_w12_quiet", tmo_c, 1'b0);
    ph = 0;
    run_div(3, 30, 1);
    chk("after_tmo_period", {tmo_a, per_a}, {1'b0, 4'd3});

    // clr with cen low and an sq edge on the same cycle.
    run_div(4, 7, 1);
    sq_v = ~sq_v;
    do_clk(1'b0, 1'b1, sq_v);
    chk("clr_out", {val_a, tmo_a, lck_a, per_a}, 7'd0);
    run_div(4, 30, 1);
    chk("after_clr_period", per_a, 4'd4);

    // Asymmetric waveform: high 3 / low 7.
    run_duty(3, 7, 6);
    chk("duty_unlocked", lck_a, 1'b0);

    // Randomized half-periods, cen density and rare clr.
    for (int j = 0; j < 300; j++) begin
      int h;
      h = $urandom_range(1, 17);
      for (int t = 0; t < h; t++) begin
        logic c, cl;
        c  = ($urandom_range(0, 3) != 0);
        cl = ($urandom_range(0, 299) == 0);
        do_clk(c, cl, sq_v);
      end
      sq_v = ~sq_v;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
